// File: rtl/alu_muldiv_seq.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle, beside the ALU.
// Optional signed support (FIX state) is compiled in with `define MULDIV_SIGNED_EN.
module alu_muldiv_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef MULDIV_SIGNED_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, FIX = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_q, op_d;
    // opnd: multiplicand or divisor (static); acc: product high half or remainder;
    // lo: multiplier shifting into product low half, or dividend shifting into quotient.
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   sum, rem_s, trial;
    logic [WIDTH-1:0] acc_n, lo_n;

`ifdef MULDIV_SIGNED_EN
    logic               sgn_q, sgn_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic [2*WIDTH-1:0] prod_neg;

    assign a_mag    = (sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag    = (sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;
    assign prod_neg = ~{acc_q, lo_q} + 1'b1;
`else
    logic unused_sgn;
    assign unused_sgn = sgn;
    assign a_mag      = a;
    assign b_mag      = b;
`endif

    // One multiply or divide iteration, both at WIDTH+1 bits.
    always_comb begin
        sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH + 1){1'b0}});
        rem_s = {acc_q, lo_q[WIDTH-1]};
        trial = rem_s - {1'b0, opnd_q};
        acc_n = acc_q;
        lo_n  = lo_q;
        if (!op_q) begin
            acc_n = sum[WIDTH:1];
            lo_n  = {sum[0], lo_q[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            acc_n = trial[WIDTH-1:0];
            lo_n  = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_n = rem_s[WIDTH-1:0];
            lo_n  = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        dbz_d    = dbz_q;
`ifdef MULDIV_SIGNED_EN
        sgn_d    = sgn_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d   = op;
                    cnt_d  = '0;
                    acc_d  = '0;
                    dbz_d  = 1'b0;
                    opnd_d = op ? b_mag : a_mag;
                    lo_d   = op ? a_mag : b_mag;
`ifdef MULDIV_SIGNED_EN
                    sgn_d   = sgn;
                    neg_a_d = sgn & a[WIDTH-1];
                    neg_b_d = sgn & b[WIDTH-1];
`endif
                    if (op && (b == '0)) begin
                        state_d  = DONE;
                        res_lo_d = '1;
                        res_hi_d = a;
                        dbz_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = acc_n;
                lo_d  = lo_n;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
`ifdef MULDIV_SIGNED_EN
                    if (sgn_q) begin
                        state_d = FIX;
                    end else begin
                        state_d  = DONE;
                        res_lo_d = lo_n;
                        res_hi_d = acc_n;
                    end
`else
                    state_d  = DONE;
                    res_lo_d = lo_n;
                    res_hi_d = acc_n;
`endif
                end
            end
`ifdef MULDIV_SIGNED_EN
            FIX: begin
                state_d = DONE;
                if (!op_q) begin
                    {res_hi_d, res_lo_d} = (neg_a_q ^ neg_b_q) ? prod_neg : {acc_q, lo_q};
                end else begin
                    res_lo_d = (neg_a_q ^ neg_b_q) ? (~lo_q + 1'b1) : lo_q;
                    res_hi_d = neg_a_q ? (~acc_q + 1'b1) : acc_q;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            dbz_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            sgn_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            dbz_q    <= dbz_d;
`ifdef MULDIV_SIGNED_EN
            sgn_q    <= sgn_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
`endif
        end
    end

`ifdef MULDIV_SIGNED_EN
    assign busy = (state_q == RUN) || (state_q == FIX);
`else
    assign busy = (state_q == RUN);
`endif
    assign done        = (state_q == DONE);
    assign result_lo   = res_lo_q;
    assign result_hi   = res_hi_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: driver pushes expected results, a negedge monitor
// pops and compares on done and tracks the expected busy window.
module tb_alu_muldiv_seq;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic         sgn = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] result_lo, result_hi;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busy_from = 0;
    int busy_to   = -1;

    logic [2*W:0] exp_q[$];   // {dbz, hi, lo}
    int           cyc_q[$];   // expected done cycle

    alu_muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .sgn(sgn),
        .a(a), .b(b), .busy(busy), .done(done),
        .result_lo(result_lo), .result_hi(result_hi), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: busy window every cycle, result fields on each done.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", {31'b0, busy}, {31'b0, (cyc >= busy_from) && (cyc <= busy_to)});
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [2*W:0] e;
                    int           ec;
                    e  = exp_q.pop_front();
                    ec = cyc_q.pop_front();
                    check("done_cycle", cyc, ec);
                    check("result_lo", {16'b0, result_lo}, {16'b0, e[W-1:0]});
                    check("result_hi", {16'b0, result_hi}, {16'b0, e[2*W-1:W]});
                    check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e[2*W]});
                end
            end
        end
    end

    task automatic issue(input logic o, input logic s, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] el, input logic [W-1:0] eh, input logic ed, input int lat);
        @(posedge clk); #1;
        op = o; sgn = s; a = ia; b = ib; start = 1'b1;
        exp_q.push_back({ed, eh, el});
        cyc_q.push_back(cyc + lat);
        busy_from = cyc + 1;
        busy_to   = cyc + lat - 1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom_range(0, 65535));
        b = W'($urandom_range(0, 65535));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("done_timeout", 32'd0, 32'd1);
            exp_q.delete();
            cyc_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #2;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_lo", {16'b0, result_lo}, 32'd0);
        check("reset_hi", {16'b0, result_hi}, 32'd0);
        check("reset_dbz", {31'b0, div_by_zero}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        issue(1'b0, 1'b0, 16'd300, 16'd200, 16'hEA60, 16'h0000, 1'b0, 17);
        wait_idle();

        // second start mid-operation must be ignored
        issue(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 17);
        repeat (9) @(posedge clk);
        #1 op = 1'b1; a = 16'h0001; b = 16'h0000; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_idle();

        issue(1'b1, 1'b0, 16'd1000, 16'd7, 16'h008E, 16'h0006, 1'b0, 17);
        wait_idle();
        issue(1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17);
        wait_idle();
        issue(1'b1, 1'b0, 16'd5, 16'd7, 16'h0000, 16'h0005, 1'b0, 17);
        wait_idle();
        issue(1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 17);
        wait_idle();

        issue(1'b1, 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1);
        wait_idle();
        issue(1'b0, 1'b0, 16'd4, 16'd4, 16'h0010, 16'h0000, 1'b0, 17);
        check("dbz_cleared", {31'b0, div_by_zero}, 32'd0);
        wait_idle();

        // reset in cycle N+8 of a multiply
        issue(1'b0, 1'b0, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b0, 17);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        cyc_q.delete();
        busy_to = -1;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_lo", {16'b0, result_lo}, 32'd0);
        check("midrst_hi", {16'b0, result_hi}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        issue(1'b0, 1'b0, 16'd3, 16'd5, 16'h000F, 16'h0000, 1'b0, 17);
        wait_idle();

`ifdef MULDIV_SIGNED_EN
        issue(1'b0, 1'b1, 16'hFFFA, 16'd7, 16'hFFD6, 16'hFFFF, 1'b0, 18);
        wait_idle();
        issue(1'b1, 1'b1, 16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, 18);
        wait_idle();
        issue(1'b1, 1'b1, 16'hFFF9, 16'h0000, 16'hFFFF, 16'hFFF9, 1'b1, 1);
        wait_idle();
        issue(1'b0, 1'b0, 16'hFFFA, 16'd7, 16'hFFD6, 16'h0006, 1'b0, 17);
        wait_idle();
`else
        // sgn has no effect: 0xFFFA * 7 is unsigned
        issue(1'b0, 1'b1, 16'hFFFA, 16'd7, 16'hFFD6, 16'h0006, 1'b0, 17);
        wait_idle();
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end
endmodule
